// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Holds the control state encoding and the saturation-value generator.
package add_sub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Widest result the saturation helper can build; wider instances are rejected at elaboration.
  localparam int unsigned SatMaxW = 64;

  // Saturation value for an overflowed result of the given width, LSB-aligned.
  function automatic logic [SatMaxW-1:0] sat_value(input logic        signed_op,
                                                   input logic        sub,
                                                   input logic        a_msb,
                                                   input int unsigned width);
    logic [SatMaxW-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < SatMaxW; i++) begin
      if (i < width) begin
        if (signed_op) begin
          v[i] = (i == width - 1) ? a_msb : ~a_msb;
        end else begin
          v[i] = ~sub;
        end
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/add_sub_digit.sv
// DIGIT-bit ripple-carry slice built from full_adder cells.
// Also exposes the carry into its top bit for signed overflow detection.
module add_sub_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cout_o,
  output logic             c_msb_in_o
);

  logic [DIGIT:0] carry;

  assign carry[0] = cin_i;

  for (genvar g = 0; g < DIGIT; g++) begin : g_fa
    full_adder u_fa (
      .a_i  (a_i[g]),
      .b_i  (b_i[g]),
      .ci_i (carry[g]),
      .s_o  (sum_o[g]),
      .co_o (carry[g+1])
    );
  end

  assign cout_o     = carry[DIGIT];
  assign c_msb_in_o = carry[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/add_sub_seq.sv
// Multi-cycle add/subtract: one shared DIGIT-bit slice walks the operands LSB first,
// then flags and optional saturation are registered on the final digit edge.
module add_sub_seq
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             signed_op_i,
  input  logic             sat_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int unsigned N    = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  if (DIGIT == 0 || WIDTH == 0 || (WIDTH % DIGIT) != 0 || WIDTH > SatMaxW) begin : g_bad_cfg
    $error("add_sub_seq: WIDTH must be a non-zero multiple of DIGIT and at most SatMaxW");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  raw_q, raw_d;
  logic              carry_q, carry_d;
  logic              sub_q, sub_d;
  logic              signed_q, signed_d;
  logic              sat_q, sat_d;
  logic              a_msb_q, a_msb_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [DIGIT-1:0]       dig_sum;
  logic                   dig_cout;
  logic                   dig_c_msb;
  logic [WIDTH+DIGIT-1:0] raw_shift;
  logic [WIDTH-1:0]       fin_raw;
  logic                   fin_ovf;
  logic [SatMaxW-1:0]     sat_full;
  logic [WIDTH-1:0]       fin_res;

  // Operands shift right each digit, so the slice always sees the low digit.
  add_sub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a_i        (a_q[DIGIT-1:0]),
    .b_i        (b_q[DIGIT-1:0]),
    .cin_i      (carry_q),
    .sum_o      (dig_sum),
    .cout_o     (dig_cout),
    .c_msb_in_o (dig_c_msb)
  );

  always_comb begin
    // Raw result fills from the top; after N digits digit 0 sits at bit 0.
    raw_shift = {dig_sum, raw_q};
    fin_raw   = raw_shift[WIDTH+DIGIT-1:DIGIT];
    fin_ovf   = signed_q ? (dig_c_msb ^ dig_cout) : (sub_q ? ~dig_cout : dig_cout);
    sat_full  = sat_value(signed_q, sub_q, a_msb_q, WIDTH);
    fin_res   = (sat_q && fin_ovf) ? sat_full[WIDTH-1:0] : fin_raw;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    raw_d    = raw_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    signed_d = signed_q;
    sat_d    = sat_q;
    a_msb_d  = a_msb_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          state_d  = StRun;
          a_d      = a_i;
          b_d      = b_i ^ {WIDTH{sub_i}};
          sub_d    = sub_i;
          signed_d = signed_op_i;
          sat_d    = sat_i;
          a_msb_d  = a_i[WIDTH-1];
          carry_d  = sub_i;
          cnt_d    = '0;
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        raw_d   = fin_raw;
        carry_d = dig_cout;
        if (cnt_q == LastCnt) begin
          state_d  = StDone;
          result_d = fin_res;
          cout_d   = dig_cout;
          ovf_d    = fin_ovf;
          zero_d   = (fin_res == '0);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      raw_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      signed_q <= 1'b0;
      sat_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      raw_q    <= raw_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      signed_q <= signed_d;
      sat_q    <= sat_d;
      a_msb_q  <= a_msb_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign result_o    = result_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;
  assign zero_o      = zero_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// Bench for add_sub_seq (WIDTH=16, DIGIT=4): directed table, handshake corners, random ops
// checked against an arithmetic reference model.
module tb_add_sub_seq;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;
  localparam int LAT = W / D;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         signed_op;
  logic         sat;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  int n_vec;
  int n_fail;

  add_sub_seq #(
    .WIDTH (W),
    .DIGIT (D)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .sub_i       (sub),
    .signed_op_i (signed_op),
    .sat_i       (sat),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .cout_o      (cout),
    .ovf_o       (ovf),
    .zero_o      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         sgn;
    logic         sat;
    logic [W-1:0] exp_res;
    logic         exp_cout;
    logic         exp_ovf;
    logic         exp_zero;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                       input logic msgn, input logic msat, output logic [W-1:0] r,
                       output logic co, output logic ov, output logic ze);
    int unsigned ua, ub, full;
    int sa, sb, sres;
    ua = ma;
    ub = mb;
    sa = $signed(ma);
    sb = $signed(mb);
    full = msub ? (ua + (32'h0000_FFFF ^ ub) + 1) : (ua + ub);
    co = full[W];
    sres = msub ? (sa - sb) : (sa + sb);
    if (msgn) ov = (sres > 32767) || (sres < -32768);
    else      ov = msub ? (ua < ub) : (full > 32'h0000_FFFF);
    r = full[W-1:0];
    if (msat && ov) begin
      if (msgn) r = ma[W-1] ? 16'h8000 : 16'h7FFF;
      else      r = msub ? 16'h0000 : 16'hFFFF;
    end
    ze = (r == '0);
  endtask

  task automatic start_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic osub,
                          input logic osgn, input logic osat);
    a = oa;
    b = ob;
    sub = osub;
    signed_op = osgn;
    sat = osat;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_op(input int hold);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                               input logic osub, input logic osgn, input logic osat,
                               input logic [W-1:0] er, input logic eco, input logic eov,
                               input logic eze, input int hold);
    int lat;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    start_op(oa, ob, osub, osgn, osat);
    wait_done(lat);
    check({tag, " latency"}, lat, LAT);
    check({tag, " result"}, result, er);
    check({tag, " cout"}, 32'(cout), 32'(eco));
    check({tag, " ovf"}, 32'(ovf), 32'(eov));
    check({tag, " zero"}, 32'(zero), 32'(eze));
    finish_op(hold);
  endtask

  initial begin
    logic [W-1:0] er, held;
    logic eco, eov, eze;
    int lat;

    n_vec = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    signed_op = 1'b0;
    sat = 1'b0;

    vecs[0] = '{16'h1234, 16'h0FED, 1'b0, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{16'h0003, 16'h0010, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{16'hFFF0, 16'h0020, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset flags", {29'd0, cout, ovf, zero}, 32'd0);

    foreach (vecs[i]) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sgn,
                    vecs[i].sat, vecs[i].exp_res, vecs[i].exp_cout, vecs[i].exp_ovf,
                    vecs[i].exp_zero, 0);
    end

    // Backpressure: DONE holds while a competing request is offered.
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1);
    wait_done(lat);
    check("bp latency", lat, LAT);
    held = result;
    check("bp result", held, 32'h7FFF);
    a = 16'h0001;
    b = 16'h0001;
    sub = 1'b0;
    signed_op = 1'b0;
    sat = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp hold out_valid", 32'(out_valid), 32'd1);
      check("bp hold in_ready", 32'(in_ready), 32'd0);
      check("bp hold result", result, 32'h7FFF);
      check("bp hold flags", {29'd0, cout, ovf, zero}, 32'b010);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp release in_ready", 32'(in_ready), 32'd1);
    check("bp release out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("bp no second accept", 32'(in_ready), 32'd1);

    // Reset two digits into RUN discards the operation.
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrun rst in_ready", 32'(in_ready), 32'd1);
    check("midrun rst out_valid", 32'(out_valid), 32'd0);
    check("midrun rst result", result, 32'd0);
    check("midrun rst flags", {29'd0, cout, ovf, zero}, 32'd0);
    repeat (LAT + 1) @(posedge clk);
    #1;
    check("midrun rst stays idle", 32'(out_valid), 32'd0);
    run_and_check("post rst", 16'h1234, 16'h0FED, 1'b0, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0,
                  1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] ra, rb;
      logic rs, rg, rt;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 4 == 0) rb = ~ra + W'($urandom_range(0, 2));
      rs = 1'($urandom);
      rg = 1'($urandom);
      rt = 1'($urandom);
      model(ra, rb, rs, rg, rt, er, eco, eov, eze);
      run_and_check($sformatf("rand%0d", i), ra, rb, rs, rg, rt, er, eco, eov, eze,
                    int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/add_sub_seq.md
Name: add_sub_seq

Overview:
Parametrised multi-cycle two's-complement adder/subtractor with valid/ready handshakes on both sides. It processes a WIDTH-bit operation DIGIT bits per cycle through one shared ripple-carry digit slice, trading latency for area. Operation is selectable per transaction: add or subtract, signed or unsigned, wrap or saturate. It also reports carry, overflow and zero flags. It sits between operand-producing datapath logic and result consumers wherever a wide add/sub is needed and combinational ripple depth is unacceptable.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT, otherwise an elaboration-time error.
DIGIT, 4, bits processed per cycle; N = WIDTH/DIGIT digit cycles per operation.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand transaction valid
in_ready  out  1  block can accept; high only in IDLE
a  in  WIDTH  operand A
b  in  WIDTH  operand B
sub  in  1  1 = A-B (B inverted, carry-in 1); 0 = A+B
signed_op  in  1  1 = two's-complement overflow/saturation rules; 0 = unsigned
sat  in  1  1 = saturate on overflow; 0 = wrap
out_valid  out  1  result valid; high only in DONE
out_ready  in  1  consumer accepts result
result  out  WIDTH  final (possibly saturated) result
cout  out  1  carry out of MSB of raw sum (for sub: 1 = no borrow)
ovf  out  1  overflow: signed_op ? (carry into MSB ^ carry out of MSB) : (sub ? ~cout : cout)
zero  out  1  result == 0 (after saturation)

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, in_ready=1, out_valid=0, result=0, cout=0, ovf=0, zero=0, digit counter=0. Reset overrides everything, including mid-RUN and mid-DONE; an in-flight op is discarded with no output.
- States: IDLE -> RUN on in_valid&&in_ready; RUN -> RUN while cnt<N-1; RUN -> DONE after digit N-1; DONE -> IDLE on out_valid&&out_ready.
- Accept edge k: latch a, b^{WIDTH{sub}}, sub, signed_op, sat; carry register <= sub; cnt <= 0.
- RUN edge k+1+i (i=0..N-1): digit i = a[i*DIGIT +: DIGIT] + b'[same] + carry. Write the sum into the raw-result register, update carry, and keep the carry into the MSB at i=N-1.
- After edge k+N: state=DONE, out_valid=1. Flags and saturation are computed combinationally from the raw result, then registered into result/cout/ovf/zero on the same edge. Latency = N cycles from accept edge to out_valid; throughput = one op per N+2 cycles minimum.
- Saturation (sat=1, ovf=1):
  - signed: result = MSB of a (latched) ? 100..0 : 011..1
  - unsigned add: all ones
  - unsigned sub: 0
  - When sat=0 or ovf=0, result = raw sum.
- DONE holds result and flags stable while out_ready=0; in_valid is ignored (in_ready=0) in RUN and DONE.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Decomposition:
- Shared package add_sub_pkg: state enum (IDLE, RUN, DONE) and a function computing the saturation value from (signed_op, sub, a_msb, WIDTH).
- One sub-module, add_sub_digit: DIGIT-bit ripple adder. Ports a, b, cin, sum, cout, plus c_msb_in (carry into its top bit), built from the existing full_adder cell.

Test Plan:
- WIDTH=16, DIGIT=4: add 0x1234+0x0FED, sub=0, wrap -> out_valid exactly 4 cycles after accept; result=0x2221, cout=0, ovf=0, zero=0.
- Unsigned sub 0x0005-0x0007, sat=0 -> result=0xFFFE, cout=0, ovf=1 (unsigned borrow); signed_op=1 -> ovf=0.
- Signed sat add 0x7FFF+0x0001 -> ovf=1, result=0x7FFF. Same with sat=0 -> result=0x8000. Signed sat sub 0x8000-0x0001 -> result=0x8000.
- Unsigned sat sub 0x0003-0x0010 -> result=0x0000, zero=1. Unsigned sat add 0xFFF0+0x0020 -> result=0xFFFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> result/flags stable, in_ready=0, no second accept; out_ready=1 -> IDLE next cycle, in_ready=1.
- rst_n=0 for one cycle during RUN (cnt=2) -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0; a new op then completes correctly.
